// File: rtl/cfu_bus_adapter.sv
// CFU bus front-end for conv1d: accepts one CPU command at a time, pulses the core,
// waits for its result (bounded by a timeout) and returns it on the response channel.
module cfu_bus_adapter #(
  parameter int                    INT32_SIZE = 32,
  parameter int                    FUNC_ID_W  = 10,
  parameter int                    TIMEOUT    = 255,
  parameter int                    TIMEOUT_W  = 8,
  parameter logic [INT32_SIZE-1:0] ERR_VALUE  = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FUNC_ID_W-1:0]  cmd_function_id,
  input  logic [INT32_SIZE-1:0] cmd_inputs_0,
  input  logic [INT32_SIZE-1:0] cmd_inputs_1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INT32_SIZE-1:0] rsp_outputs_0,
  output logic                  core_en,
  output logic [6:0]            core_cmd,
  output logic [INT32_SIZE-1:0] core_inp0,
  output logic [INT32_SIZE-1:0] core_inp1,
  input  logic [INT32_SIZE-1:0] core_ret,
  input  logic                  core_out_valid,
  output logic                  err_sticky,
  output logic                  busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the sender
  // holds valid and payload stable until that edge, and never retracts valid.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT[TIMEOUT_W-1:0];

  state_t               state, next_state;
  logic [TIMEOUT_W-1:0] count;
  logic                 accept;
  logic                 illegal;
  logic                 timed_out;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign illegal   = |cmd_function_id[FUNC_ID_W-1:7];
  assign timed_out = (count == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = illegal ? RESP : ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (core_out_valid || timed_out) next_state = RESP;
      RESP:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are registered copies of the next state, so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_outputs_0 <= '0;
      core_en       <= 1'b0;
      core_cmd      <= '0;
      core_inp0     <= '0;
      core_inp1     <= '0;
      err_sticky    <= 1'b0;
      busy          <= 1'b0;
      count         <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
      core_en   <= (next_state == ISSUE);
      busy      <= (next_state != IDLE);
      case (state)
        IDLE: if (accept) begin
          core_cmd  <= cmd_function_id[6:0];
          core_inp0 <= cmd_inputs_0;
          core_inp1 <= cmd_inputs_1;
          if (illegal) begin
            rsp_outputs_0 <= ERR_VALUE;
            err_sticky    <= 1'b1;
          end
        end
        ISSUE: count <= '0;
        WAIT: begin
          // A result arriving on the timeout edge still wins.
          if (core_out_valid) begin
            rsp_outputs_0 <= core_ret;
          end else if (timed_out) begin
            rsp_outputs_0 <= ERR_VALUE;
            err_sticky    <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_bus_adapter.sv
// Directed bench for cfu_bus_adapter: a hand-driven CPU and conv1d core, with each
// scenario checking its own expected values.
module tb_cfu_bus_adapter;

  localparam int TIMEOUT = 255;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_function_id = '0;
  logic [31:0] cmd_inputs_0 = '0;
  logic [31:0] cmd_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_outputs_0;
  logic        core_en;
  logic [6:0]  core_cmd;
  logic [31:0] core_inp0;
  logic [31:0] core_inp1;
  logic [31:0] core_ret = '0;
  logic        core_out_valid = 1'b0;
  logic        err_sticky;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int en_count = 0;

  cfu_bus_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_function_id(cmd_function_id),
    .cmd_inputs_0(cmd_inputs_0), .cmd_inputs_1(cmd_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_outputs_0(rsp_outputs_0),
    .core_en(core_en), .core_cmd(core_cmd), .core_inp0(core_inp0), .core_inp1(core_inp1),
    .core_ret(core_ret), .core_out_valid(core_out_valid),
    .err_sticky(err_sticky), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (core_en) en_count++;

  // driver tasks (each leaves the bench just after a falling edge)
  task automatic issue_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_function_id = fid; cmd_inputs_0 = a; cmd_inputs_1 = b; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_outputs_0, core_en, core_cmd, core_inp0, core_inp1, err_sticky, busy} !== '0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b rv=%b out=%h en=%b cmd=%h err=%b busy=%b required all 0",
               cmd_ready, rsp_valid, rsp_outputs_0, core_en, core_cmd, err_sticky, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    #1 checks++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: %b required 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: %b required 1", cmd_ready); end
  endtask

  task automatic test_basic();
    int n;
    int en0 = en_count;
    issue_cmd(10'h005, 32'h11, 32'h22);
    checks++;
    if (core_en !== 1'b1 || core_cmd !== 7'd5 || core_inp0 !== 32'h11 || core_inp1 !== 32'h22 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_issue: en=%b cmd=%h in0=%h in1=%h busy=%b rdy=%b required 1 05 11 22 1 0",
               core_en, core_cmd, core_inp0, core_inp1, busy, cmd_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (core_en !== 1'b0 || core_cmd !== 7'd5 || core_inp0 !== 32'h11) begin
      fails++;
      $display("FAIL basic_wait_hold: en=%b cmd=%h in0=%h required 0 05 11", core_en, core_cmd, core_inp0);
    end
    @(posedge clk); @(negedge clk);
    core_ret = 32'h1234; core_out_valid = 1'b1;
    wait_rsp(20, n);
    core_out_valid = 1'b0;
    checks++;
    if (n !== 1 || rsp_outputs_0 !== 32'h1234 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL basic_rsp: wait=%0d out=%h err=%b required 1 00001234 0", n, rsp_outputs_0, err_sticky);
    end
    checks++;
    if (en_count - en0 !== 1) begin fails++; $display("FAIL basic_en_cycles: %0d required 1", en_count - en0); end
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: rv=%b rdy=%b busy=%b required 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_back_pressure();
    int n;
    int bad = 0;
    int en0;
    issue_cmd(10'h00A, 32'hA5A5_0001, 32'h0000_0002);
    @(posedge clk); @(negedge clk);
    core_ret = 32'hCAFE_0042; core_out_valid = 1'b1;
    wait_rsp(20, n);
    core_out_valid = 1'b0;
    checks++;
    if (n !== 1) begin fails++; $display("FAIL bp_min_latency: waited %0d required 1", n); end
    en0 = en_count;
    cmd_function_id = 10'h003; cmd_inputs_0 = 32'h77; cmd_inputs_1 = 32'h88; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'hCAFE_0042 || cmd_ready !== 1'b0) bad++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (bad !== 0 || en_count !== en0) begin
      fails++;
      $display("FAIL bp_hold: bad_cycles=%0d new_en=%0d required 0 0", bad, en_count - en0);
    end
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || core_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_handshake: rv=%b rdy=%b en=%b busy=%b required 0 1 0 0", rsp_valid, cmd_ready, core_en, busy);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core_en !== 1'b1 || core_cmd !== 7'd3 || core_inp0 !== 32'h77) begin
      fails++;
      $display("FAIL bp_next_accept: en=%b cmd=%h in0=%h required 1 03 77", core_en, core_cmd, core_inp0);
    end
    @(posedge clk); @(negedge clk);
    core_ret = 32'h5; core_out_valid = 1'b1;
    wait_rsp(20, n);
    core_out_valid = 1'b0;
    checks++;
    if (rsp_outputs_0 !== 32'h5) begin fails++; $display("FAIL bp_second_rsp: %h required 00000005", rsp_outputs_0); end
    finish_rsp();
  endtask

  task automatic test_simultaneous();
    issue_cmd(10'h001, 32'h1, 32'h2);
    // Counter equals TIMEOUT on the (TIMEOUT+2)th edge after the accept edge.
    for (int i = 0; i < TIMEOUT + 1; i++) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL sim_early_rsp: rv=%b required 0", rsp_valid); end
    core_ret = 32'h7; core_out_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    core_out_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_outputs_0 !== 32'h7 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL sim_valid_wins: rv=%b out=%h err=%b required 1 00000007 0", rsp_valid, rsp_outputs_0, err_sticky);
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int n;
    issue_cmd(10'h002, 32'h9, 32'hA);
    wait_rsp(400, n);
    checks++;
    if (n !== TIMEOUT + 2 || rsp_outputs_0 !== ERR || err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL timeout_rsp: edges=%0d out=%h err=%b required %0d deadbeef 1", n, rsp_outputs_0, err_sticky, TIMEOUT + 2);
    end
    finish_rsp();
    issue_cmd(10'h004, 32'h3, 32'h4);
    @(posedge clk); @(negedge clk);
    core_ret = 32'h0BAD_F00D; core_out_valid = 1'b1;
    wait_rsp(20, n);
    core_out_valid = 1'b0;
    checks++;
    if (rsp_outputs_0 !== 32'h0BAD_F00D || err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky: out=%h err=%b required 0badf00d 1", rsp_outputs_0, err_sticky);
    end
    finish_rsp();
  endtask

  task automatic test_illegal();
    int en0 = en_count;
    issue_cmd(10'h080, 32'h1, 32'h1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_outputs_0 !== ERR || err_sticky !== 1'b1 || core_en !== 1'b0) begin
      fails++;
      $display("FAIL illegal_rsp: rv=%b out=%h err=%b en=%b required 1 deadbeef 1 0", rsp_valid, rsp_outputs_0, err_sticky, core_en);
    end
    finish_rsp();
    checks++;
    if (en_count !== en0) begin fails++; $display("FAIL illegal_no_en: en_cycles=%0d required 0", en_count - en0); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int bad = 0;
    issue_cmd(10'h006, 32'hAA, 32'hBB);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({cmd_ready, rsp_valid, rsp_outputs_0, core_en, core_cmd, core_inp0, core_inp1, err_sticky, busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset_values: rdy=%b rv=%b out=%h en=%b cmd=%h in0=%h err=%b busy=%b required all 0",
               cmd_ready, rsp_valid, rsp_outputs_0, core_en, core_cmd, core_inp0, err_sticky, busy);
    end
    core_ret = 32'h1111; core_out_valid = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) core_out_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL mid_reset_no_rsp: bad_cycles=%0d required 0", bad); end
    issue_cmd(10'h007, 32'h5, 32'h6);
    @(posedge clk); @(negedge clk);
    core_ret = 32'h0000_ABCD; core_out_valid = 1'b1;
    wait_rsp(20, n);
    core_out_valid = 1'b0;
    checks++;
    if (n !== 1 || rsp_outputs_0 !== 32'h0000_ABCD || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_fresh: wait=%0d out=%h err=%b required 1 0000abcd 0", n, rsp_outputs_0, err_sticky);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_simultaneous();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
